// File: rtl/seq_div_unit.sv
// seq_div_unit: sequential unsigned restoring divider with valid/ready handshakes.
// Takes one (a, b) pair at a time. It produces one quotient bit per clock and
// returns quot/rem WIDTH cycles after the pair is accepted. A zero divisor skips
// the iteration and reports div_by_zero on the cycle after acceptance.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   rst_n        - synchronous active-low reset
//   in_valid     - operand pair offered
//   in_ready     - block is idle and can accept a pair (decoded from state)
//   a, b         - unsigned dividend / divisor
//   out_valid    - result available (decoded from state)
//   out_ready    - downstream accepts the result
//   quot, rem    - unsigned quotient / remainder, held until the next result
//   div_by_zero  - current result came from b == 0
module seq_div_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_by_zero
);

   // One extra bit on the partial remainder so the compare/subtract cannot overflow.
   localparam int unsigned PW = WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] dvd_q;     // dividend bits shift out the top, quotient bits shift in the bottom
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] cnt_q;
   logic [PW-1:0]    prem_q;

   logic             accept;
   logic             last_step;
   logic             b_zero;
   logic [PW-1:0]    prem_sh;
   logic [PW-1:0]    prem_nxt;
   logic             q_bit;
   logic [WIDTH-1:0] dvd_nxt;

   // Handshake decode
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;
   assign b_zero    = (b == '0);
   assign last_step = (cnt_q == WIDTH'(1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = b_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (last_step) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // One restoring-division step
   always_comb begin
      prem_sh  = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      q_bit    = (prem_sh >= {1'b0, dvs_q});
      prem_nxt = q_bit ? (prem_sh - {1'b0, dvs_q}) : prem_sh;
      dvd_nxt  = {dvd_q[WIDTH-2:0], q_bit};
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         prem_q      <= '0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  dvd_q  <= a;
                  dvs_q  <= b;
                  prem_q <= '0;
                  cnt_q  <= WIDTH'(WIDTH);
                  if (b_zero) begin
                     quot        <= '0;
                     rem         <= a;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               dvd_q  <= dvd_nxt;
               prem_q <= prem_nxt;
               cnt_q  <= cnt_q - WIDTH'(1);
               if (last_step) begin
                  quot        <= dvd_nxt;
                  rem         <= prem_nxt[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed corner cases, backpressure,
// reset abort and a randomised stream checked through an expected-result queue.
module tb_seq_div_unit;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             div_by_zero;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dz;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   seq_div_unit #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quot        (quot),
      .rem         (rem),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Offer a pair until accepted; push the expected result.
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      exp_t e;
      bit   rdy;
      int   n;
      n        = 0;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      do begin
         rdy = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!rdy && n < 50);
      in_valid = 1'b0;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      vectors++;
      if (rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL issue_timeout: in_ready got %b want 1 within 50 cycles", rdy);
      end
      if (bv == '0) begin
         e.q  = '0;
         e.r  = av;
         e.dz = 1'b1;
      end else begin
         e.q  = av / bv;
         e.r  = av % bv;
         e.dz = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Wait for a result, check latency and value, optionally backpressure, consume it.
   task automatic collect(input string name, input int hold, input bit early, input bit junk_in);
      exp_t e;
      int   cyc;
      int   lat;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL %s_scoreboard: queue size got 0 want >0", name);
         return;
      end
      e         = sb.pop_front();
      lat       = e.dz ? 0 : WIDTH;
      cyc       = 0;
      out_ready = early;
      while (!out_valid && cyc < WIDTH + 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (out_valid !== 1'b1 || cyc != lat) begin
         miscompares++;
         $display("FAIL %s_latency: out_valid %b after %0d cycles, want 1 after %0d", name, out_valid, cyc, lat);
      end
      vectors++;
      if (quot !== e.q) begin
         miscompares++;
         $display("FAIL %s_quot: got %0h want %0h", name, quot, e.q);
      end
      vectors++;
      if (rem !== e.r) begin
         miscompares++;
         $display("FAIL %s_rem: got %0h want %0h", name, rem, e.r);
      end
      vectors++;
      if (div_by_zero !== e.dz) begin
         miscompares++;
         $display("FAIL %s_dbz: got %b want %b", name, div_by_zero, e.dz);
      end
      if (!early) begin
         in_valid = junk_in;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.q || rem !== e.r || div_by_zero !== e.dz) begin
               miscompares++;
               $display("FAIL %s_hold: cycle %0d ov=%b ir=%b q=%0h r=%0h want ov=1 ir=0 q=%0h r=%0h",
                        name, i, out_valid, in_ready, quot, rem, e.q, e.r);
            end
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot !== e.q || rem !== e.r) begin
         miscompares++;
         $display("FAIL %s_consume: ov=%b ir=%b q=%0h r=%0h want ov=0 ir=1 q=%0h r=%0h",
                  name, out_valid, in_ready, quot, rem, e.q, e.r);
      end
   endtask

   task automatic check_idle_clear(input string name);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quot !== '0 || rem !== '0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: ir=%b ov=%b q=%0h r=%0h dbz=%b want ir=1 ov=0 q=0 r=0 dbz=0",
                  name, in_ready, out_valid, quot, rem, div_by_zero);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = WIDTH'(9);
      b         = WIDTH'(3);
      out_ready = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_idle_clear("reset_state");
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      check_idle_clear("post_reset_idle");
   endtask

   task automatic test_directed();
      issue(WIDTH'(100), WIDTH'(7));
      collect("d_100_7", 0, 1'b0, 1'b0);
      issue(WIDTH'(16'hFFFF), WIDTH'(1));
      collect("d_ffff_1", 0, 1'b0, 1'b0);
      issue(WIDTH'(16'hFFFF), WIDTH'(16'hFFFF));
      collect("d_ffff_ffff", 0, 1'b0, 1'b0);
      issue(WIDTH'(5), WIDTH'(9));
      collect("d_5_9", 0, 1'b0, 1'b0);
      issue(WIDTH'(0), WIDTH'(13));
      collect("d_0_13", 0, 1'b0, 1'b0);
      issue(WIDTH'(1234), WIDTH'(0));
      collect("d_1234_0", 0, 1'b0, 1'b0);
      issue(WIDTH'(77), WIDTH'(3));
      collect("d_clear_dbz", 0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      issue(WIDTH'(40000), WIDTH'(123));
      collect("bp_40000_123", 10, 1'b0, 1'b1);
      issue(WIDTH'(999), WIDTH'(0));
      collect("bp_dbz", 10, 1'b0, 1'b1);
   endtask

   task automatic test_reset_abort();
      issue(WIDTH'(1000), WIDTH'(3));
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      check_idle_clear("abort_state");
      @(posedge clk);
      #1;
      check_idle_clear("abort_no_result");
      issue(WIDTH'(50), WIDTH'(5));
      collect("abort_50_5", 0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      int               sel;
      bit               early;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         av  = WIDTH'($urandom);
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       bv = '0;
            1:       bv = WIDTH'(1);
            2:       bv = av;
            3, 4, 5: bv = WIDTH'($urandom_range(1, 255));
            default: bv = WIDTH'($urandom);
         endcase
         early = ($urandom_range(0, 3) == 0);
         issue(av, bv);
         collect("rand", int'($urandom_range(0, 3)), early, 1'b0);
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL rand_leftover: queue size got %0d want 0", sb.size());
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time got 2ms want completion earlier");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      #1;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
